// File: rtl/ahblite_busmatrix_outputstage_pkg.sv
// rtl/ahblite_busmatrix_outputstage_pkg.sv - AHB-Lite transfer/response codes shared by the output stage
package ahblite_busmatrix_outputstage_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   // NONSEQ or SEQ: the port wants a new address phase.
   function automatic logic htrans_is_req(input logic [1:0] trans);
      return trans[1];
   endfunction

   // SEQ or BUSY: the port is continuing a burst it already owns.
   function automatic logic htrans_is_cont(input logic [1:0] trans);
      return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
   endfunction

endpackage

// File: rtl/ahblite_rr_arbiter2.sv
// rtl/ahblite_rr_arbiter2.sv - two-port round-robin arbiter with burst lock and stall freeze
module ahblite_rr_arbiter2
   import ahblite_busmatrix_outputstage_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic [1:0] cont_i,
   input  logic       ready_i,
   input  logic       err_i,
   output logic       gnt_valid_o,
   output logic       gnt_port_o
);

   logic last_gnt_q, last_gnt_d;
   logic lock_q, lock_d;
   logic lock_port_q, lock_port_d;
   logic hold_q, hold_d;
   logic hold_valid_q, hold_valid_d;
   logic hold_port_q, hold_port_d;

   logic gv;
   logic gp;

   // A stalled address phase stays with whoever owned it when the stall began.
   always_comb begin
      gv = 1'b0;
      gp = 1'b0;
      if (hold_q) begin
         gv = hold_valid_q;
         gp = hold_port_q;
      end else if (lock_q && cont_i[lock_port_q]) begin
         gv = 1'b1;
         gp = lock_port_q;
      end else if (req_i[0] && req_i[1]) begin
         gv = 1'b1;
         gp = ~last_gnt_q;
      end else if (req_i[0] || req_i[1]) begin
         gv = 1'b1;
         gp = req_i[1];
      end
      if (rst_i) begin
         gv = 1'b0;
      end
   end

   assign gnt_valid_o = gv;
   assign gnt_port_o  = gp;

   always_comb begin
      last_gnt_d   = last_gnt_q;
      lock_d       = lock_q;
      lock_port_d  = lock_port_q;
      hold_d       = ~ready_i;
      hold_valid_d = gv;
      hold_port_d  = gp;
      if (ready_i) begin
         lock_d = gv & (req_i[gp] | cont_i[gp]);
         if (gv) begin
            last_gnt_d  = gp;
            lock_port_d = gp;
         end
      end
      if (err_i) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_gnt_q   <= 1'b1;
         lock_q       <= 1'b0;
         lock_port_q  <= 1'b0;
         hold_q       <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_port_q  <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         lock_q       <= lock_d;
         lock_port_q  <= lock_port_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_port_q  <= hold_port_d;
      end
   end

endmodule

// File: rtl/ahblite_busmatrix_outputstage.sv
// rtl/ahblite_busmatrix_outputstage.sv - bus matrix slave-side output stage for two decoder ports
module ahblite_busmatrix_outputstage
   import ahblite_busmatrix_outputstage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL_P0,
   input  logic [ADDR_W-1:0] HADDR_P0,
   input  logic [1:0]        HTRANS_P0,
   input  logic              HWRITE_P0,
   input  logic [2:0]        HSIZE_P0,
   input  logic [DATA_W-1:0] HWDATA_P0,
   input  logic              HSEL_P1,
   input  logic [ADDR_W-1:0] HADDR_P1,
   input  logic [1:0]        HTRANS_P1,
   input  logic              HWRITE_P1,
   input  logic [2:0]        HSIZE_P1,
   input  logic [DATA_W-1:0] HWDATA_P1,
   output logic              ACTIVE_P0,
   output logic              ACTIVE_P1,
   output logic              HSEL_S,
   output logic [ADDR_W-1:0] HADDR_S,
   output logic [1:0]        HTRANS_S,
   output logic              HWRITE_S,
   output logic [2:0]        HSIZE_S,
   output logic [DATA_W-1:0] HWDATA_S,
   output logic              HREADY_S,
   input  logic              HREADYOUT_S,
   input  logic [1:0]        HRESP_S,
   input  logic [DATA_W-1:0] HRDATA_S,
   output logic              HREADYOUT,
   output logic [1:0]        HRESP,
   output logic [DATA_W-1:0] HRDATA
);

   logic [1:0] req;
   logic [1:0] cont;
   logic       gnt_valid;
   logic       gnt_port;
   logic       dp_valid_q, dp_valid_d;
   logic       dp_port_q, dp_port_d;

   assign req[0]  = HSEL_P0 & htrans_is_req(HTRANS_P0);
   assign req[1]  = HSEL_P1 & htrans_is_req(HTRANS_P1);
   assign cont[0] = HSEL_P0 & htrans_is_cont(HTRANS_P0);
   assign cont[1] = HSEL_P1 & htrans_is_cont(HTRANS_P1);

   ahblite_rr_arbiter2 u_arb (
      .clk_i       (HCLK),
      .rst_i       (HRESET),
      .req_i       (req),
      .cont_i      (cont),
      .ready_i     (HREADYOUT_S),
      .err_i       (HRESP_S == HRESP_ERROR),
      .gnt_valid_o (gnt_valid),
      .gnt_port_o  (gnt_port)
   );

   assign ACTIVE_P0 = gnt_valid & ~gnt_port;
   assign ACTIVE_P1 = gnt_valid & gnt_port;

   always_comb begin
      HSEL_S   = 1'b0;
      HADDR_S  = '0;
      HTRANS_S = HTRANS_IDLE;
      HWRITE_S = 1'b0;
      HSIZE_S  = 3'b000;
      if (ACTIVE_P0) begin
         HSEL_S   = HSEL_P0;
         HADDR_S  = HADDR_P0;
         HTRANS_S = HTRANS_P0;
         HWRITE_S = HWRITE_P0;
         HSIZE_S  = HSIZE_P0;
      end else if (ACTIVE_P1) begin
         HSEL_S   = HSEL_P1;
         HADDR_S  = HADDR_P1;
         HTRANS_S = HTRANS_P1;
         HWRITE_S = HWRITE_P1;
         HSIZE_S  = HSIZE_P1;
      end
   end

   always_comb begin
      dp_valid_d = dp_valid_q;
      dp_port_d  = dp_port_q;
      if (HREADYOUT_S) begin
         dp_valid_d = gnt_valid;
         if (gnt_valid) begin
            dp_port_d = gnt_port;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_valid_q <= 1'b0;
         dp_port_q  <= 1'b0;
      end else begin
         dp_valid_q <= dp_valid_d;
         dp_port_q  <= dp_port_d;
      end
   end

   // Without an owned data phase the decoders see an idle, always-ready slave.
   assign HWDATA_S  = dp_valid_q ? (dp_port_q ? HWDATA_P1 : HWDATA_P0) : '0;
   assign HREADY_S  = HREADYOUT_S;
   assign HREADYOUT = dp_valid_q ? HREADYOUT_S : 1'b1;
   assign HRESP     = dp_valid_q ? HRESP_S : HRESP_OKAY;
   assign HRDATA    = dp_valid_q ? HRDATA_S : '0;

endmodule

// File: doc/ahblite_busmatrix_outputstage.md
Name: ahblite_busmatrix_outputstage

Overview:
- Slave-side output stage of the AHB-Lite bus matrix: one instance per slave (DTCM, CAMERA, ...).
- Takes address-phase requests from two input-stage decoders (port 0 = system decoder, port 1 = ACC decoder).
- Arbitrates between them round-robin, holding the grant for the length of a burst.
- Drives one AHB-Lite slave, returns ACTIVE per port, and forwards slave HREADYOUT/HRESP/HRDATA back to the decoders.

Parameters:
ADDR_W, 32, address width forwarded to slave
DATA_W, 32, HWDATA/HRDATA width

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous, active-high reset
HSEL_P0  in  1  port-0 decoder select for this slave
HADDR_P0  in  ADDR_W  port-0 address
HTRANS_P0  in  2  port-0 transfer type
HWRITE_P0  in  1  port-0 direction
HSIZE_P0  in  3  port-0 size
HWDATA_P0  in  DATA_W  port-0 write data (data phase)
HSEL_P1, HADDR_P1, HTRANS_P1, HWRITE_P1, HSIZE_P1, HWDATA_P1  in  (as port 0)  port-1 equivalents
ACTIVE_P0  out  1  port 0 owns the current address phase
ACTIVE_P1  out  1  port 1 owns the current address phase
HSEL_S  out  1  slave select
HADDR_S  out  ADDR_W  slave address
HTRANS_S  out  2  slave transfer type
HWRITE_S  out  1  slave direction
HSIZE_S  out  3  slave size
HWDATA_S  out  DATA_W  slave write data
HREADY_S  out  1  HREADY to slave
HREADYOUT_S  in  1  slave HREADYOUT
HRESP_S  in  2  slave response
HRDATA_S  in  DATA_W  slave read data
HREADYOUT  out  1  forwarded slave ready, to decoders
HRESP  out  2  forwarded slave response
HRDATA  out  DATA_W  forwarded read data

Behaviour:
- Request: req_x = HSEL_Px & HTRANS_Px[1] (NONSEQ or SEQ).
- State registers:
  - last_gnt: 1 bit; reset 1, so port 0 wins the first tie.
  - lock: 1 bit; reset 0.
  - lock_port: 1 bit; reset 0.
  - dp_valid: 1 bit; reset 0.
  - dp_port: 1 bit; reset 0.
- Grant (combinational):
  - If lock = 1: grant lock_port.
  - Else, one request: grant that port.
  - Else, both requesting: grant ~last_gnt.
  - Else, no request: no grant.
- ACTIVE_Px = 1 only when port x is granted. At most one ACTIVE is high per cycle.
- Slave address outputs:
  - HSEL_S/HADDR_S/HTRANS_S/HWRITE_S/HSIZE_S are muxed from the granted port.
  - With no grant: HSEL_S=0, HTRANS_S=IDLE (2'b00), HADDR_S=0, HWRITE_S=0, HSIZE_S=0.
- Update on HREADYOUT_S=1 (address phase accepted):
  - dp_valid <= any grant; dp_port <= granted port.
  - If granted: last_gnt <= granted port.
  - lock <= 1 if the granted port's next beat continues a burst, i.e. the accepted HTRANS is NONSEQ or SEQ and the port still has HSEL with HTRANS SEQ/BUSY in the following cycle. Implement this as: lock held while the owner presents SEQ or BUSY; cleared when the owner presents IDLE/NONSEQ or drops HSEL.
  - lock_port <= granted port.
- HREADYOUT_S=0: all state registers hold. Grant is frozen to the registered owner: address outputs must not change while the slave stalls.
- Data-phase outputs:
  - HWDATA_S = dp_port ? HWDATA_P1 : HWDATA_P0; 0 when !dp_valid.
  - HREADY_S = HREADYOUT_S.
  - HREADYOUT = HREADYOUT_S when dp_valid, else 1.
  - HRESP = HRESP_S when dp_valid, else 2'b00.
  - HRDATA = HRDATA_S when dp_valid, else 0.
- Non-granted port: its decoder sees ACTIVE=0 and holds its transfer; no state is kept here for it.
- ERROR response (HRESP_S=01): lock clears on the first ERROR cycle; no other special handling.
- Reset mid-transfer: all registers go to reset values immediately, outputs go IDLE, and no data phase is reported.
- Latency: grant is zero-cycle. A write data phase appears one accepted cycle after its address phase.

Decomposition:
- Shared package/header: HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) and HRESP codes (OKAY, ERROR).
- One natural sub-module: ahblite_rr_arbiter2, holding req/lock/last_gnt and producing the grant. Datapath muxes stay in the top level.

Test Plan:
- Single port 0 NONSEQ read to 0x20000010, slave ready → ACTIVE_P0=1, HADDR_S=0x20000010; next cycle HRDATA=HRDATA_S, dp_port=0.
- Both ports NONSEQ in the same cycle after reset → port 0 granted first; both still requesting next cycle → port 1 granted (round-robin).
- Port 1 INCR4 burst (NONSEQ + 3 SEQ) while port 0 requests continuously → ACTIVE_P1 held for all 4 beats; port 0 granted on the 5th cycle.
- Slave inserts 2 wait states (HREADYOUT_S=0) during a port 0 write → HADDR_S/HTRANS_S stable; HWDATA_S=HWDATA_P0; HREADYOUT=0 for 2 cycles.
- Slave returns ERROR on a port 1 SEQ beat → HRESP=01 forwarded, lock cleared, pending port 0 request granted next accepted cycle.
- HRESET asserted mid-burst → ACTIVE_P0/P1=0, HTRANS_S=IDLE, HREADYOUT=1 and HRESP=00 immediately (asynchronous).
